// File: rtl/nes_controller_responder.sv
// NES controller responder: answers an external NES reader's latch/clock
// strobes with the eight button states, serialised LSB (A) first, active-low.
// Latch and pulse are asynchronous to clk and pass through synchronizer
// chains; all outputs come straight from flops so data_out never glitches.
module nes_controller_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout,
  output logic [7:0] frame_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LATCHED = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   latch_prev_q;
  logic                   pulse_prev_q;

  logic [1:0]    state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [TW-1:0] tcnt_inc;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_q, timeout_d;

  logic latch_s;
  logic pulse_s;
  logic latch_rise;
  logic latch_fall;
  logic pulse_rise;

  // Synchronizer chains (bit 0 is the first stage) plus last-value flops for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch_in};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
      latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
      pulse_prev_q <= pulse_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign pulse_rise = pulse_s & ~pulse_prev_q;
  assign tcnt_inc   = tcnt_q + TW'(1);

  // Frame sequencing; a latch rising edge wins over everything, including a same-cycle pulse edge.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_idx_d     = bit_idx_q;
    tcnt_d        = tcnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    timeout_d     = 1'b0;
    if (latch_rise) begin
      state_d   = ST_LATCHED;
      sr_d      = ~buttons;
      bit_idx_d = 4'd0;
      tcnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LATCHED: begin
          if (latch_fall) begin
            // sr keeps the load taken while latch was still high
            state_d   = ST_SHIFT;
            bit_idx_d = 4'd0;
            tcnt_d    = '0;
          end else if (latch_s) begin
            sr_d = ~buttons;
          end else begin
            sr_d = sr_q;
          end
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            sr_d      = {1'b1, sr_q[7:1]};
            bit_idx_d = bit_idx_q + 4'd1;
            tcnt_d    = '0;
            if (bit_idx_q == 4'd7) begin
              state_d       = ST_DONE;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
            end else begin
              state_d = ST_SHIFT;
            end
          end else if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            sr_d      = 8'hFF;
            tcnt_d    = '0;
            bit_idx_d = 4'd0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        ST_DONE: begin
          // extra reader clocks after the 8th bit are ignored here
          state_d = ST_DONE;
        end
        default: begin
          state_d   = ST_IDLE;
          sr_d      = 8'hFF;
          bit_idx_d = 4'd0;
          tcnt_d    = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with the state flops.
  always_comb begin
    if ((state_d == ST_LATCHED) || (state_d == ST_SHIFT)) begin
      data_out_d = sr_d[0];
      busy_d     = 1'b1;
    end else begin
      data_out_d = 1'b1;
      busy_d     = 1'b0;
    end
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sr_q          <= 8'hFF;
      bit_idx_q     <= 4'd0;
      tcnt_q        <= '0;
      frame_count_q <= 8'd0;
      data_out_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_idx_q     <= bit_idx_d;
      tcnt_q        <= tcnt_d;
      frame_count_q <= frame_count_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout     = timeout_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Bench for nes_controller_responder: directed scenarios plus randomized
// frames, checked against a reader-level model of what a NES reader sees.
module tb_nes_controller_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       latch_in;
  logic       pulse_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       busy;
  logic       frame_done;
  logic       timeout;
  logic [7:0] frame_count;

  int         n_checks = 0;
  int         n_err    = 0;
  int         fd_hi    = 0;
  int         to_hi    = 0;
  logic [7:0] model_cnt = 8'd0;

  nes_controller_responder #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .latch_in(latch_in),
    .pulse_in(pulse_in),
    .buttons(buttons),
    .data_out(data_out),
    .busy(busy),
    .frame_done(frame_done),
    .timeout(timeout),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Count clock cycles in which each pulse output is high.
  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_hi <= fd_hi + 1;
    if (timeout === 1'b1) to_hi <= to_hi + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the reader sees after k clock pulses: button k (active-low), then 1s.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    logic [7:0] inv;
    inv = ~b;
    if (k < 8) return inv[k];
    else return 1'b1;
  endfunction

  task automatic one_pulse();
    pulse_in = 1'b1;
    cyc($urandom_range(3, 6));
    pulse_in = 1'b0;
    cyc($urandom_range(3, 6));
  endtask

  // Latch phase then npulses reader clocks; verbose enables per-bit checks.
  task automatic run_frame(input logic [7:0] b, input int npulses, input bit verbose);
    int fd0;
    fd0 = fd_hi;
    buttons  = 8'($urandom);
    latch_in = 1'b1;
    cyc(6);
    buttons = b;
    cyc(5);
    if (verbose) begin
      check("latched_data", {31'd0, data_out}, {31'd0, exp_bit(b, 0)});
      check("latched_busy", {31'd0, busy}, 32'd1);
    end
    latch_in = 1'b0;
    cyc(6);
    buttons = 8'($urandom);
    if (verbose) check("shift_start_data", {31'd0, data_out}, {31'd0, exp_bit(b, 0)});
    for (int k = 1; k <= npulses; k++) begin
      one_pulse();
      if (verbose) begin
        check($sformatf("bit_after_pulse%0d", k), {31'd0, data_out}, {31'd0, exp_bit(b, k)});
        check($sformatf("busy_after_pulse%0d", k), {31'd0, busy}, (k < 8) ? 32'd1 : 32'd0);
      end
    end
    if (npulses >= 8) model_cnt = model_cnt + 8'd1;
    cyc(2);
    if (verbose) begin
      check("frame_done_cycles", fd_hi - fd0, (npulses >= 8) ? 32'd1 : 32'd0);
      check("frame_count", {24'd0, frame_count}, {24'd0, model_cnt});
    end
  endtask

  initial begin
    logic [7:0] b;
    int         fd0;
    int         to0;
    int         waited;

    rst = 1'b0; latch_in = 1'b0; pulse_in = 1'b0; buttons = 8'd0;
    cyc(3);
    check("rst_data_out", {31'd0, data_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    rst = 1'b1;
    cyc(3);

    // Full frame with A and Start pressed.
    run_frame(8'b0000_1001, 8, 1'b1);
    check("full_frame_count", {24'd0, frame_count}, 32'd1);
    check("full_frame_idle_data", {31'd0, data_out}, 32'd1);

    // Overrun: extra pulses after the 8th keep data high, one frame_done.
    run_frame(8'hFF, 12, 1'b1);

    // Random frames to bring the count to 5.
    for (int i = 0; i < 3; i++) run_frame(8'($urandom), $urandom_range(8, 10), 1'b1);
    check("count_before_reset", {24'd0, frame_count}, 32'd5);

    // Asynchronous reset in the middle of a shift.
    b = 8'($urandom);
    buttons = b; latch_in = 1'b1; cyc(6);
    latch_in = 1'b0; cyc(6);
    one_pulse(); one_pulse();
    #2 rst = 1'b0;
    #1;
    check("async_rst_data_out", {31'd0, data_out}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_frame_count", {24'd0, frame_count}, 32'd0);
    model_cnt = 8'd0;
    // Latch already high when reset releases must still start a frame.
    b = 8'($urandom);
    buttons  = b;
    latch_in = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(SYNC + 4);
    check("latch_high_at_release_busy", {31'd0, busy}, 32'd1);
    check("latch_high_at_release_data", {31'd0, data_out}, {31'd0, exp_bit(b, 0)});
    run_frame(b, 8, 1'b1);

    // Abort: latch reasserted after 3 pulses.
    fd0 = fd_hi;
    b = 8'($urandom);
    buttons = b; latch_in = 1'b1; cyc(6);
    latch_in = 1'b0; cyc(6);
    for (int k = 0; k < 3; k++) one_pulse();
    b = 8'($urandom);
    buttons  = b;
    latch_in = 1'b1;
    cyc(6);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_reload_data", {31'd0, data_out}, {31'd0, exp_bit(b, 0)});
    check("abort_no_frame_done", fd_hi - fd0, 32'd0);
    check("abort_count", {24'd0, frame_count}, {24'd0, model_cnt});
    run_frame(b, 8, 1'b1);

    // Timeout: two pulses then silence.
    to0 = to_hi;
    b = 8'($urandom);
    buttons = b; latch_in = 1'b1; cyc(6);
    latch_in = 1'b0; cyc(6);
    pulse_in = 1'b1; cyc(3); pulse_in = 1'b0; cyc(3);
    pulse_in = 1'b1; cyc(3); pulse_in = 1'b0; cyc(3);
    waited = 0;
    while ((timeout !== 1'b1) && (waited < 3 * TMO)) begin
      cyc(1);
      waited++;
    end
    check("timeout_seen_in_window",
          {31'd0, (waited >= TMO - 10) && (waited <= TMO + 2)}, 32'd1);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_data_out", {31'd0, data_out}, 32'd1);
    cyc(3);
    check("timeout_one_cycle", to_hi - to0, 32'd1);
    check("timeout_count_kept", {24'd0, frame_count}, {24'd0, model_cnt});

    // Latch and pulse rising together: latch wins, bit index stays at 0.
    b = 8'($urandom);
    buttons  = b;
    latch_in = 1'b1;
    pulse_in = 1'b1;
    cyc(6);
    check("simul_busy", {31'd0, busy}, 32'd1);
    check("simul_data", {31'd0, data_out}, {31'd0, exp_bit(b, 0)});
    pulse_in = 1'b0;
    cyc(4);
    run_frame(b, 8, 1'b1);

    // Randomized frames, some too short to complete.
    for (int i = 0; i < 6; i++) run_frame(8'($urandom), $urandom_range(5, 11), 1'b1);

    // Drive the frame counter around its wrap point.
    while (model_cnt != 8'd0) run_frame(8'($urandom), 8, 1'b0);
    check("frame_count_wrap", {24'd0, frame_count}, 32'd0);
    run_frame(8'($urandom), 8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
